lemmings_array: RTL and testbench

- N-channel walker/faller/digger FSM array, the parametrised successor of the single-lemming controller.
- Each channel runs an independent 7-state FSM with its own bump, ground and dig inputs.
- The fatal-fall threshold is a parameter rather than a fixed constant.
- Adds a per-channel dead flag and an aggregate dead count for the scoreboard/status logic that sits above the game-tick domain.

---
 rtl/lemmings_pkg.sv | 22 ++
 rtl/lemmings_array_if.sv | 40 ++++
 rtl/lemming_fsm.sv | 72 +++++++
 rtl/lemmings_array.sv | 57 +++++
 tb/tb_lemmings_array.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lemmings_pkg.sv
// Shared types and width helpers for the lemmings channel array.
package lemmings_pkg;

   typedef enum logic [2:0] {
      StWl,
      StWr,
      StFallL,
      StFallR,
      StDigL,
      StDigR,
      StDead
   } lem_state_e;

   function automatic int unsigned cnt_width(int unsigned fall_limit);
      return $clog2(fall_limit + 1);
   endfunction

   function automatic int unsigned dc_width(int unsigned num_lem);
      return $clog2(num_lem + 1);
   endfunction

endpackage

// File: rtl/lemmings_array_if.sv
// Per-channel input/output bundle for lemmings_array; revive exists only when
// LEMMINGS_REVIVE_EN is defined.
interface lemmings_array_if
   import lemmings_pkg::*;
#(
   parameter int unsigned NUM_LEM = 4
);
   localparam int unsigned DC_W = dc_width(NUM_LEM);

   logic [NUM_LEM-1:0] bump_left;
   logic [NUM_LEM-1:0] bump_right;
   logic [NUM_LEM-1:0] ground;
   logic [NUM_LEM-1:0] dig;
`ifdef LEMMINGS_REVIVE_EN
   logic [NUM_LEM-1:0] revive;
`endif
   logic [NUM_LEM-1:0] walk_left;
   logic [NUM_LEM-1:0] walk_right;
   logic [NUM_LEM-1:0] aaah;
   logic [NUM_LEM-1:0] digging;
   logic [NUM_LEM-1:0] dead;
   logic [DC_W-1:0]    dead_count;

   modport master (
      output bump_left, bump_right, ground, dig,
`ifdef LEMMINGS_REVIVE_EN
      output revive,
`endif
      input  walk_left, walk_right, aaah, digging, dead, dead_count
   );

   modport slave (
      input  bump_left, bump_right, ground, dig,
`ifdef LEMMINGS_REVIVE_EN
      input  revive,
`endif
      output walk_left, walk_right, aaah, digging, dead, dead_count
   );

endinterface

// File: rtl/lemming_fsm.sv
// One lemming channel: walk/fall/dig/dead FSM with a saturating fall counter.
module lemming_fsm
   import lemmings_pkg::*;
#(
   parameter int unsigned FALL_LIMIT = 20
) (
   input  logic clk,
   input  logic areset,
   input  logic i_bump_left,
   input  logic i_bump_right,
   input  logic i_ground,
   input  logic i_dig,
   input  logic i_revive,
   output logic o_walk_left,
   output logic o_walk_right,
   output logic o_aaah,
   output logic o_digging,
   output logic o_dead
);
   localparam int unsigned CNT_W = cnt_width(FALL_LIMIT);
   localparam logic [CNT_W-1:0] CntMax = CNT_W'(FALL_LIMIT);

   lem_state_e       r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         r_state <= StWl;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         StWl: begin
            if (!i_ground)        w_state_nxt = StFallL;
            else if (i_dig)       w_state_nxt = StDigL;
            else if (i_bump_left) w_state_nxt = StWr;
         end
         StWr: begin
            if (!i_ground)         w_state_nxt = StFallR;
            else if (i_dig)        w_state_nxt = StDigR;
            else if (i_bump_right) w_state_nxt = StWl;
         end
         StFallL: if (i_ground) w_state_nxt = (r_cnt >= CntMax) ? StDead : StWl;
         StFallR: if (i_ground) w_state_nxt = (r_cnt >= CntMax) ? StDead : StWr;
         StDigL:  if (!i_ground) w_state_nxt = StFallL;
         StDigR:  if (!i_ground) w_state_nxt = StFallR;
         StDead:  if (i_revive) w_state_nxt = StWl;
         default: w_state_nxt = StWl;
      endcase

      // Counter only advances while staying in the same fall; any exit clears it.
      w_cnt_nxt = '0;
      if ((r_state == StFallL || r_state == StFallR) && (w_state_nxt == r_state)) begin
         w_cnt_nxt = (r_cnt == CntMax) ? r_cnt : r_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      o_walk_left  = (r_state == StWl);
      o_walk_right = (r_state == StWr);
      o_aaah       = (r_state == StFallL) || (r_state == StFallR);
      o_digging    = (r_state == StDigL) || (r_state == StDigR);
      o_dead       = (r_state == StDead);
   end

endmodule

// File: rtl/lemmings_array.sv
// NUM_LEM independent lemming channels plus a dead-channel count.
// Optional LEMMINGS_REVIVE_EN adds a per-channel revive input.
module lemmings_array
   import lemmings_pkg::*;
#(
   parameter int unsigned NUM_LEM    = 4,
   parameter int unsigned FALL_LIMIT = 20
) (
   input logic             clk,
   input logic             areset,
   lemmings_array_if.slave bus
);
   localparam int unsigned DC_W = dc_width(NUM_LEM);

   logic [NUM_LEM-1:0] w_walk_left, w_walk_right, w_aaah, w_digging, w_dead;
   logic [DC_W-1:0]    w_dead_count;

   for (genvar g = 0; g < NUM_LEM; g++) begin : g_lem
      logic w_revive;
`ifdef LEMMINGS_REVIVE_EN
      assign w_revive = bus.revive[g];
`else
      assign w_revive = 1'b0;
`endif
      lemming_fsm #(
         .FALL_LIMIT (FALL_LIMIT)
      ) u_fsm (
         .clk          (clk),
         .areset       (areset),
         .i_bump_left  (bus.bump_left[g]),
         .i_bump_right (bus.bump_right[g]),
         .i_ground     (bus.ground[g]),
         .i_dig        (bus.dig[g]),
         .i_revive     (w_revive),
         .o_walk_left  (w_walk_left[g]),
         .o_walk_right (w_walk_right[g]),
         .o_aaah       (w_aaah[g]),
         .o_digging    (w_digging[g]),
         .o_dead       (w_dead[g])
      );
   end

   always_comb begin
      w_dead_count = '0;
      for (int i = 0; i < NUM_LEM; i++) begin
         w_dead_count = w_dead_count + DC_W'(w_dead[i]);
      end
   end

   assign bus.walk_left  = w_walk_left;
   assign bus.walk_right = w_walk_right;
   assign bus.aaah       = w_aaah;
   assign bus.digging    = w_digging;
   assign bus.dead       = w_dead;
   assign bus.dead_count = w_dead_count;

endmodule

// File: tb/tb_lemmings_array.sv
// Directed + randomised scoreboard bench for lemmings_array (4 channels, limit 20).
module tb_lemmings_array;
   import lemmings_pkg::*;

   localparam int unsigned NL = 4;
   localparam int unsigned FL = 20;
   localparam int MWL = 0, MWR = 1, MFL = 2, MFR = 3, MDL = 4, MDR = 5, MDD = 6;

   typedef struct packed {
      logic [NL-1:0] wl;
      logic [NL-1:0] wr;
      logic [NL-1:0] fa;
      logic [NL-1:0] dg;
      logic [NL-1:0] dd;
      logic [2:0]    dc;
   } obs_t;

   logic clk = 1'b0;
   logic areset;
   always #5 clk = ~clk;

   lemmings_array_if #(.NUM_LEM(NL)) bus ();

   lemmings_array #(
      .NUM_LEM    (NL),
      .FALL_LIMIT (FL)
   ) dut (
      .clk    (clk),
      .areset (areset),
      .bus    (bus)
   );

   obs_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   m_st[NL];
   int   m_k[NL];

   function automatic obs_t sample();
      obs_t s;
      s.wl = bus.walk_left;
      s.wr = bus.walk_right;
      s.fa = bus.aaah;
      s.dg = bus.digging;
      s.dd = bus.dead;
      s.dc = bus.dead_count;
      return s;
   endfunction

   function automatic obs_t model_obs();
      obs_t s;
      s = '0;
      for (int c = 0; c < NL; c++) begin
         s.wl[c] = (m_st[c] == MWL);
         s.wr[c] = (m_st[c] == MWR);
         s.fa[c] = (m_st[c] == MFL) || (m_st[c] == MFR);
         s.dg[c] = (m_st[c] == MDL) || (m_st[c] == MDR);
         s.dd[c] = (m_st[c] == MDD);
         s.dc    = s.dc + 3'(s.dd[c]);
      end
      return s;
   endfunction

   function automatic void model_reset();
      for (int c = 0; c < NL; c++) begin
         m_st[c] = MWL;
         m_k[c]  = 0;
      end
   endfunction

   // m_k counts aaah cycles of the current fall, including the cycle now in progress.
   function automatic void model_next();
      for (int c = 0; c < NL; c++) begin
         logic g, bl, br, dg, rv;
         g  = bus.ground[c];
         bl = bus.bump_left[c];
         br = bus.bump_right[c];
         dg = bus.dig[c];
`ifdef LEMMINGS_REVIVE_EN
         rv = bus.revive[c];
`else
         rv = 1'b0;
`endif
         case (m_st[c])
            MWL: if (!g) begin m_st[c] = MFL; m_k[c] = 1; end
                 else if (dg) m_st[c] = MDL;
                 else if (bl) m_st[c] = MWR;
            MWR: if (!g) begin m_st[c] = MFR; m_k[c] = 1; end
                 else if (dg) m_st[c] = MDR;
                 else if (br) m_st[c] = MWL;
            MFL, MFR: if (g) m_st[c] = (m_k[c] > FL) ? MDD : ((m_st[c] == MFL) ? MWL : MWR);
                      else m_k[c]++;
            MDL: if (!g) begin m_st[c] = MFL; m_k[c] = 1; end
            MDR: if (!g) begin m_st[c] = MFR; m_k[c] = 1; end
            MDD: if (rv) m_st[c] = MWL;
            default: m_st[c] = MWL;
         endcase
      end
   endfunction

   task automatic check(input string tag, input obs_t got, input obs_t exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_int(input string tag, input int got, input int exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input string tag);
      model_next();
      exp_q.push_back(model_obs());
      @(posedge clk);
      #1;
      check(tag, sample(), exp_q.pop_front());
   endtask

   task automatic drive(input logic [NL-1:0] bl, input logic [NL-1:0] br,
                        input logic [NL-1:0] g, input logic [NL-1:0] dg);
      bus.bump_left  = bl;
      bus.bump_right = br;
      bus.ground     = g;
      bus.dig        = dg;
   endtask

   task automatic do_reset(input string tag);
      areset = 1'b1;
      drive('0, '0, '1, '0);
      #2;
      model_reset();
      check(tag, sample(), model_obs());
      @(negedge clk);
      areset = 1'b0;
   endtask

   initial begin
      int cnt;
      areset = 1'b0;
`ifdef LEMMINGS_REVIVE_EN
      bus.revive = '0;
`endif
      drive('0, '0, '1, '0);
      #1;
      do_reset("reset");
      check_int("rst_walk_left", int'(bus.walk_left), 4'hF);
      check_int("rst_dead_count", int'(bus.dead_count), 0);

      repeat (3) step("idle");
      drive(4'b0100, '0, '1, '0);
      step("bump2");
      check_int("bump2_walk_right", int'(bus.walk_right), 4'b0100);
      drive('0, '0, '1, '0);
      step("bump2_hold");

      // 20-cycle fall on channel 0 survives
      drive('0, '0, 4'b1110, '0);
      cnt = 0;
      repeat (20) begin
         step("fall20");
         cnt += int'(bus.aaah[0]);
      end
      drive('0, '0, '1, '0);
      step("land20");
      cnt += int'(bus.aaah[0]);
      check_int("aaah20_len", cnt, 20);
      check_int("alive20", int'({bus.walk_left[0], bus.dead[0]}), 2);

      // 21-cycle fall kills, and death is sticky
      drive('0, '0, 4'b1110, '0);
      repeat (21) step("fall21");
      drive('0, '0, '1, '0);
      step("land21");
      check_int("dead21", int'(bus.dead[0]), 1);
      check_int("dead21_count", int'(bus.dead_count), 1);
      repeat (8) begin
         drive(4'($urandom_range(0, 1)), 4'($urandom_range(0, 1)),
               {3'b111, 1'($urandom_range(0, 1))}, 4'($urandom_range(0, 1)));
         step("dead_hold");
      end
      check_int("dead_sticky", int'(bus.dead[0]), 1);

      // Channel 1: WR, dig beats bump, dig then fall, short landing to WR
      drive(4'b0010, '0, '1, '0);
      step("ch1_to_wr");
      drive('0, 4'b0010, '1, 4'b0010);
      step("ch1_dig");
      check_int("dig_beats_bump", int'(bus.digging[1]), 1);
      drive('0, '0, 4'b1101, '0);
      step("ch1_dig_fall");
      check_int("dig_fall_aaah", int'(bus.aaah[1]), 1);
      repeat (2) step("ch1_falling");
      drive('0, '0, '1, '0);
      step("ch1_land");
      check_int("ch1_walk_right", int'(bus.walk_right[1]), 1);

      // Staggered 25-cycle falls on channels 0..2, then reset mid-fall on ch3
      do_reset("reset2");
      for (int t = 0; t < 33; t++) begin
         logic [NL-1:0] g;
         for (int c = 0; c < 3; c++) g[c] = !(t >= 3 * c && t < 3 * c + 25);
         g[3] = !(t >= 22);
         drive('0, '0, g, '0);
         step("stagger");
      end
      check_int("stagger_count", int'(bus.dead_count), 3);
      check_int("ch3_midfall", int'(bus.aaah[3]), 1);
      #2;
      areset = 1'b1;
      #1;
      model_reset();
      check("async_reset", sample(), model_obs());
      drive('0, '0, '1, '0);
      @(negedge clk);
      areset = 1'b0;

      // Random traffic, mostly grounded
      for (int t = 0; t < 80; t++) begin
         drive(4'($urandom & $urandom), 4'($urandom & $urandom),
               4'(~($urandom & $urandom & $urandom)), 4'($urandom & $urandom & $urandom));
         step("random");
      end

`ifdef LEMMINGS_REVIVE_EN
      do_reset("reset3");
      drive('0, '0, 4'b1110, '0);
      repeat (21) step("rv_fall21");
      drive('0, '0, '1, '0);
      step("rv_land");
      check_int("rv_dead", int'(bus.dead[0]), 1);
      bus.revive = 4'b0011;
      step("revive");
      bus.revive = '0;
      check_int("revived_wl", int'(bus.walk_left[1:0]), 3);
      drive('0, '0, 4'b1110, '0);
      repeat (20) step("rv_fall20");
      drive('0, '0, '1, '0);
      step("rv_land20");
      check_int("rv_survive", int'(bus.dead[0]), 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
